// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed hex display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned HEX_W      = 4;
  localparam int unsigned VALUE_W    = 16;

  // One-hot digit select; DIG_NONE is the blanked (all digits off) select
  typedef enum logic [NUM_DIGITS-1:0] {
    DIG_NONE = 4'b0000,
    DIG_0    = 4'b0001,
    DIG_1    = 4'b0010,
    DIG_2    = 4'b0100,
    DIG_3    = 4'b1000
  } digit_sel_t;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  function automatic digit_sel_t digit_onehot(input digit_idx_t idx);
    digit_sel_t sel;
    sel = DIG_0;
    case (idx)
      2'd0: sel = DIG_0;
      2'd1: sel = DIG_1;
      2'd2: sel = DIG_2;
      2'd3: sel = DIG_3;
      default: sel = DIG_0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// Dwell prescaler: counts 0..SCAN_DIV-1 and pulses tick at terminal count.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == TERMINAL);

  // Free-running dwell counter, wraps to zero on terminal count
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed hex display scanner with frame-aligned value update.
// Optional leading-zero blanking: define DISPLAY_SCANNER_LZB_EN.
module display_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [display_pkg::VALUE_W-1:0]        in_value,
  output logic                                   in_ready,
  output logic [display_pkg::HEX_W-1:0]          hex,
  output logic [display_pkg::NUM_DIGITS-1:0]     digit_en,
  output logic                                   frame_start
);

  import display_pkg::*;

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic               tick;
  logic               wrap;
  logic               accept;
  digit_idx_t         idx;
  digit_idx_t         idx_next;
  logic [VALUE_W-1:0] disp;
  logic [VALUE_W-1:0] disp_next;
  logic [VALUE_W-1:0] pend;
  logic               pend_valid;
  logic [HEX_W-1:0]   hex_next;
  digit_sel_t         sel_next;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign wrap = tick && (idx == LAST_IDX);
  // Pending slot frees on the wrap tick, so a new value may land in the same cycle
  assign in_ready = !reset && (!pend_valid || wrap);
  assign accept   = in_valid && in_ready;

  // Next digit's select and nibble, taken from the display value it will show
  always_comb begin
    idx_next  = idx + 1'b1;
    disp_next = (wrap && pend_valid) ? pend : disp;
    hex_next  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == digit_idx_t'(i)) begin
        hex_next = disp_next[i*HEX_W +: HEX_W];
      end
    end
    sel_next = digit_onehot(idx_next);
`ifdef DISPLAY_SCANNER_LZB_EN
    // Digit 0 is never blanked so an all-zero value still shows "0"
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (idx_next == digit_idx_t'(i) && (disp_next >> (i*HEX_W)) == '0) begin
        sel_next = DIG_NONE;
        hex_next = '0;
      end
    end
`endif
  end

  // Scan position and registered display outputs, stepping on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      hex         <= '0;
      digit_en    <= DIG_0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        idx      <= idx_next;
        hex      <= hex_next;
        digit_en <= sel_next;
      end
    end
  end

  // Pending value drains into the display register only at frame wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp <= disp_next;
      if (accept) begin
        pend       <= in_value;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (SCAN_DIV=4); model tracks cycles since reset.
// Leading-zero blanking expectations follow DISPLAY_SCANNER_LZB_EN.
module tb_display_scanner;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = DIV * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_value;
  logic        in_ready;
  logic [3:0]  hex;
  logic [3:0]  digit_en;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_scanner #(
    .SCAN_DIV  (DIV),
    .NUM_DIGITS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_ready   (in_ready),
    .hex        (hex),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = cycles since reset released; pending kept as a queue
  int unsigned k = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend[$];
  bit          m_on = 1'b0;

  function automatic bit m_wrap();
    return (k % FRAME) == FRAME - 1;
  endfunction

  function automatic logic m_ready();
    return !reset && (m_pend.size() == 0 || m_wrap());
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      k = 0;
      m_disp = '0;
      m_pend.delete();
      m_on = 1'b1;
    end else if (m_on) begin
      acc = in_valid && m_ready();
      if (m_wrap() && m_pend.size() > 0) m_disp = m_pend.pop_front();
      if (acc) m_pend.push_back(in_value);
      k++;
    end
  end

  // Compare every cycle once the model is live
  always @(negedge clk) begin
    int unsigned d;
    logic [3:0] es;
    logic [3:0] eh;
    logic       efs;
    if (m_on) begin
      d   = (k / DIV) % 4;
      es  = 4'b0001 << d;
      eh  = m_disp[4*d +: 4];
      efs = (k > 0) && (k % FRAME == 0);
`ifdef DISPLAY_SCANNER_LZB_EN
      if (d > 0 && (m_disp >> (4*d)) == 16'h0) begin
        es = 4'b0000;
        eh = 4'h0;
      end
`endif
      chk("cmp_digit_en", digit_en, es);
      chk("cmp_hex", hex, eh);
      chk("cmp_frame_start", frame_start, efs);
      chk("cmp_in_ready", in_ready, m_ready());
    end
  end

  // Drive inputs for the current cycle, then advance one clock
  task automatic go(input logic v, input logic [15:0] val, input logic r);
    in_valid = v;
    in_value = val;
    reset    = r;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) go(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] rv;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    repeat (3) go(1'b0, 16'h0, 1'b1);
    chk("rst_digit_en", digit_en, 4'b0001);
    chk("rst_hex", hex, 4'h0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // Idle scan
    run(4);  chk("idle_k4_en", digit_en, 4'b0010); chk("idle_k4_hex", hex, 4'h0);
    run(8);  chk("idle_k12_en", digit_en, 4'b1000);
    run(4);  chk("idle_k16_fs", frame_start, 1'b1); chk("idle_k16_en", digit_en, 4'b0001);
    run(4);

    // Mid-frame offer of 1A2F
    go(1'b1, 16'h1A2F, 1'b0);
    in_valid = 1'b0; #1;
    chk("offer_ready_drop", in_ready, 1'b0);
    run(10);
    chk("offer_old_hex", hex, 4'h0);
    chk("wrap_ready", in_ready, 1'b1);
    run(1);
    chk("new_frame_fs", frame_start, 1'b1);
    chk("new_frame_hex0", hex, 4'hF);
    run(4); chk("new_frame_hex1", hex, 4'h2);
    run(4); chk("new_frame_hex2", hex, 4'hA);
    run(4); chk("new_frame_hex3", hex, 4'h1);
    run(6);

    // Back-to-back offers; second lands on the wrap tick
    go(1'b1, 16'h1111, 1'b0);
    in_valid = 1'b1; in_value = 16'h2222; #1;
    chk("b2b_blocked", in_ready, 1'b0);
    for (int unsigned i = 0; i < 12; i++) go(1'b1, 16'h2222, 1'b0);
    #1;
    chk("b2b_wrap_ready", in_ready, 1'b1);
    go(1'b1, 16'h2222, 1'b0);
    in_valid = 1'b0; #1;
    chk("coinc_ready_low", in_ready, 1'b0);
    chk("coinc_hex_old", hex, 4'h1);
    chk("coinc_fs", frame_start, 1'b1);
    run(12); chk("coinc_hex3_old", hex, 4'h1);
    run(4);  chk("coinc_next_hex", hex, 4'h2);

    // Reset during digit 2 with pending full
    run(20);
    go(1'b1, 16'h3333, 1'b0);
    run(4);
    chk("pre_rst_en", digit_en, 4'b0100);
    go(1'b0, 16'h0, 1'b1);
    reset = 1'b0; in_valid = 1'b0; #1;
    chk("midrst_en", digit_en, 4'b0001);
    chk("midrst_hex", hex, 4'h0);
    chk("midrst_ready", in_ready, 1'b1);
    run(16);
    chk("midrst_pend_lost", hex, 4'h0);
    chk("midrst_fs", frame_start, 1'b1);

    // Leading-zero value 0030
    go(1'b1, 16'h0030, 1'b0);
    run(15);
    chk("lzb_d0_en", digit_en, 4'b0001); chk("lzb_d0_hex", hex, 4'h0);
    run(4);
    chk("lzb_d1_en", digit_en, 4'b0010); chk("lzb_d1_hex", hex, 4'h3);
    run(4);
`ifdef DISPLAY_SCANNER_LZB_EN
    chk("lzb_d2_en", digit_en, 4'b0000);
`else
    chk("lzb_d2_en", digit_en, 4'b0100);
`endif
    chk("lzb_d2_hex", hex, 4'h0);
    run(4);
`ifdef DISPLAY_SCANNER_LZB_EN
    chk("lzb_d3_en", digit_en, 4'b0000);
`else
    chk("lzb_d3_en", digit_en, 4'b1000);
`endif

    // Randomized traffic with occasional resets
    for (int unsigned i = 0; i < 3000; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      go($urandom_range(0, 3) == 0, rv, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
